// File: rtl/pc_ras.sv
// Fetch program counter with trap/redirect handling, compressed stepping and a circular return-address stack.
// Latency: every next-PC and RAS update becomes visible one clock after the qualifying edge; cur is purely registered.
// Backpressure: stall holds cur and freezes the RAS; trap and redirect still take effect while stalled.
module pc_ras #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4,
    parameter bit              C_EXT     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect,
    input  logic            rel,
    input  logic [XLEN-1:0] tgt,
    input  logic            step_half,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] cur,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] abs_tgt;
    logic [XLEN-1:0] next_pc;
    logic            ras_upd;
    logic            do_push;
    logic            do_pop;
    logic            do_swap;

    assign step    = (C_EXT && step_half) ? XLEN'(2) : XLEN'(4);
    assign seq_pc  = cur + step;
    assign abs_tgt = {tgt[XLEN-1:1], 1'b0};
    assign top_inc = top + PTR_W'(1);
    assign top_dec = top - PTR_W'(1);

    // Status flags decode the registered count, so they move on the same edge as cur.
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_CNT);

    // With compressed instructions only byte alignment is illegal; otherwise the low two bits must be clear.
    assign misalign = C_EXT ? cur[0] : (cur[1] | cur[0]);

    // Next-PC selection: trap beats redirect, both beat stall; a return pops the RAS or falls back to tgt when empty.
    always_comb begin
        next_pc = seq_pc;
        if (trap) begin
            next_pc = trap_vec;
        end else if (redirect) begin
            next_pc = rel ? (cur + tgt) : abs_tgt;
        end else if (ras_pop && !stall && !ras_empty) begin
            next_pc = ras_mem[top];
        end else if (ras_pop && !stall) begin
            next_pc = abs_tgt;
        end else if (stall) begin
            next_pc = cur;
        end
    end

    // RAS operation decode; redirect does not block it so calls and mispredicted returns still maintain the stack.
    always_comb begin
        ras_upd = !trap && !stall;
        do_swap = ras_upd && ras_push && ras_pop && !ras_empty;
        do_push = ras_upd && ras_push && !do_swap;
        do_pop  = ras_upd && ras_pop && !ras_push && !ras_empty;
    end

    // PC, top pointer and occupancy; a full push wraps top and silently overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= RESET_VEC;
            top   <= '0;
            count <= '0;
        end else begin
            cur <= next_pc;
            if (do_push) begin
                top <= top_inc;
                if (count != FULL_CNT) begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                top   <= top_dec;
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) begin
                ras_mem[top_inc] <= seq_pc;
            end else if (do_swap) begin
                ras_mem[top] <= seq_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_VEC = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, trap = 1'b0, redirect = 1'b0, rel = 1'b0;
    logic        step_half = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
    logic [31:0] trap_vec = '0, tgt = '0;

    logic [31:0] cur0, cur1;
    logic        e0, e1, f0, f1, m0, m1;

    int total = 0;
    int bad = 0;

    // Reference state: PC per variant and the RAS as a bounded queue (newest at the back).
    logic [31:0] m_cur0, m_cur1;
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];

    always #5 clk = ~clk;

    pc_ras #(.XLEN(32), .RESET_VEC(RST_VEC), .RAS_DEPTH(DEPTH), .C_EXT(1'b0)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vec(trap_vec),
        .redirect(redirect), .rel(rel), .tgt(tgt), .step_half(step_half),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .cur(cur0), .ras_empty(e0), .ras_full(f0), .misalign(m0));

    pc_ras #(.XLEN(32), .RESET_VEC(RST_VEC), .RAS_DEPTH(DEPTH), .C_EXT(1'b1)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vec(trap_vec),
        .redirect(redirect), .rel(rel), .tgt(tgt), .step_half(step_half),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .cur(cur1), .ras_empty(e1), .ras_full(f1), .misalign(m1));

    task automatic model_one(input bit c);
        logic [31:0] pc, nxt, ret, abs_t;
        logic [31:0] q[$];
        bit          empty;
        if (c) begin pc = m_cur1; q = mq1; end else begin pc = m_cur0; q = mq0; end
        ret   = pc + ((c && step_half) ? 32'd2 : 32'd4);
        abs_t = {tgt[31:1], 1'b0};
        empty = (q.size() == 0);
        if (rst) begin
            nxt = RST_VEC;
            q.delete();
        end else begin
            if (trap)                          nxt = trap_vec;
            else if (redirect)                 nxt = rel ? pc + tgt : abs_t;
            else if (ras_pop && !stall && !empty) nxt = q[q.size()-1];
            else if (ras_pop && !stall)        nxt = abs_t;
            else if (stall)                    nxt = pc;
            else                               nxt = ret;
            if (!trap && !stall) begin
                if (ras_push && ras_pop && !empty) begin
                    q[q.size()-1] = ret;
                end else if (ras_push) begin
                    q.push_back(ret);
                    if (q.size() > DEPTH) void'(q.pop_front());
                end else if (ras_pop && !empty) begin
                    void'(q.pop_back());
                end
            end
        end
        if (c) begin m_cur1 = nxt; mq1 = q; end else begin m_cur0 = nxt; mq0 = q; end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        model_one(1'b0);
        model_one(1'b1);
    endtask

    task automatic clr;
        rst = 0; stall = 0; trap = 0; redirect = 0; rel = 0;
        step_half = 0; ras_push = 0; ras_pop = 0; tgt = '0; trap_vec = '0;
    endtask

    task automatic jump(input logic [31:0] a);
        clr(); redirect = 1; tgt = a; tick(); clr();
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        rst = 1; tick(); tick();
        total++; if (cur0 !== RST_VEC || cur1 !== RST_VEC) begin bad++; $display("FAIL reset_cur: got %h/%h want %h", cur0, cur1, RST_VEC); end
        total++; if ({e0, f0, e1, f1} !== 4'b1010) begin bad++; $display("FAIL reset_flags: got %b want 1010", {e0, f0, e1, f1}); end
        clr();
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = RST_VEC + 32'(4 * i);
            total++; if (cur0 !== exp || cur1 !== exp || e0 !== 1'b1) begin bad++; $display("FAIL idle_step%0d: got %h/%h empty=%b want %h empty=1", i, cur0, cur1, e0, exp); end
        end
    endtask

    task automatic test_stall_redirect;
        jump(32'h200);
        total++; if (cur0 !== 32'h200) begin bad++; $display("FAIL abs_jump: got %h want 200", cur0); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (cur0 !== 32'h200 || cur1 !== 32'h200) begin bad++; $display("FAIL stall_hold%0d: got %h/%h want 200", i, cur0, cur1); end
        end
        redirect = 1; rel = 1; tgt = 32'hFFFF_FFF0;
        tick();
        total++; if (cur0 !== 32'h1F0 || cur1 !== 32'h1F0) begin bad++; $display("FAIL rel_redirect_in_stall: got %h/%h want 1f0", cur0, cur1); end
        clr();
    endtask

    task automatic test_call_return;
        jump(32'h300);
        step_half = 1; ras_push = 1; redirect = 1; rel = 0; tgt = 32'h501;
        tick();
        total++; if (cur0 !== 32'h500 || cur1 !== 32'h500 || e1 !== 1'b0) begin bad++; $display("FAIL call: got %h/%h empty=%b want 500 empty=0", cur0, cur1, e1); end
        clr(); tick();
        total++; if (cur1 !== 32'h504) begin bad++; $display("FAIL after_call: got %h want 504", cur1); end
        ras_pop = 1; tick();
        total++; if (cur1 !== 32'h302) begin bad++; $display("FAIL ret_half: got %h want 302", cur1); end
        total++; if (cur0 !== 32'h304) begin bad++; $display("FAIL ret_word: got %h want 304", cur0); end
        total++; if (e0 !== 1'b1 || e1 !== 1'b1) begin bad++; $display("FAIL ret_empty: got %b%b want 11", e0, e1); end
        clr();
    endtask

    task automatic test_ras_depth;
        logic [31:0] exp;
        jump(32'h0C);
        for (int i = 1; i <= 5; i++) begin
            ras_push = 1; redirect = 1; tgt = 32'(16 * i + 12);
            tick();
            if (i == 3) begin total++; if (f0 !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0", f0); end end
            if (i >= 4) begin total++; if (f0 !== 1'b1 || f1 !== 1'b1) begin bad++; $display("FAIL full_push%0d: got %b%b want 11", i, f0, f1); end end
        end
        clr();
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1; tick();
            exp = 32'h50 - 32'(16 * i);
            total++; if (cur0 !== exp || cur1 !== exp) begin bad++; $display("FAIL pop%0d: got %h/%h want %h", i, cur0, cur1, exp); end
        end
        total++; if (e0 !== 1'b1 || f0 !== 1'b0) begin bad++; $display("FAIL drained: got e=%b f=%b want e=1 f=0", e0, f0); end
        tgt = 32'h80; tick();
        total++; if (cur0 !== 32'h80 || e0 !== 1'b1 || e1 !== 1'b1) begin bad++; $display("FAIL empty_pop: got %h e=%b want 80 e=1", cur0, e0); end
        clr();
    endtask

    task automatic test_trap_reset;
        jump(32'h80);
        ras_push = 1; redirect = 1; tgt = 32'h40; tick(); clr();
        trap = 1; trap_vec = 32'h8; redirect = 1; tgt = 32'h600; ras_push = 1; stall = 1;
        tick();
        total++; if (cur0 !== 32'h8 || cur1 !== 32'h8) begin bad++; $display("FAIL trap: got %h/%h want 8", cur0, cur1); end
        total++; if (e0 !== 1'b0 || f0 !== 1'b0) begin bad++; $display("FAIL trap_ras: got e=%b f=%b want e=0 f=0", e0, f0); end
        clr(); ras_pop = 1; tick();
        total++; if (cur0 !== 32'h84 || e0 !== 1'b1) begin bad++; $display("FAIL trap_ras_top: got %h e=%b want 84 e=1", cur0, e0); end
        clr();
        ras_push = 1; tick(); tick();
        rst = 1; tick();
        total++; if (cur0 !== RST_VEC || e0 !== 1'b1 || e1 !== 1'b1) begin bad++; $display("FAIL mid_reset: got %h e=%b want %h e=1", cur0, e0, RST_VEC); end
        clr(); ras_pop = 1; tgt = 32'h91; tick();
        total++; if (cur0 !== 32'h90) begin bad++; $display("FAIL post_reset_pop: got %h want 90", cur0); end
        clr();
    endtask

    task automatic test_wrap_misalign;
        jump(32'hFFFF_FFFC);
        tick();
        total++; if (cur0 !== 32'h0 || cur1 !== 32'h0) begin bad++; $display("FAIL wrap: got %h/%h want 0", cur0, cur1); end
        jump(32'h6);
        total++; if (cur0 !== 32'h6 || m0 !== 1'b1) begin bad++; $display("FAIL misalign_word: got %h m=%b want 6 m=1", cur0, m0); end
        total++; if (m1 !== 1'b0) begin bad++; $display("FAIL misalign_half: got %b want 0", m1); end
        redirect = 1; rel = 1; tgt = 32'h1; tick(); clr();
        total++; if (cur1 !== 32'h7 || m1 !== 1'b1) begin bad++; $display("FAIL odd_rel: got %h m=%b want 7 m=1", cur1, m1); end
    endtask

    task automatic test_random;
        logic [9:0] got, exp;
        rst = 1; tick(); clr();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(63) == 0);
            trap      = ($urandom_range(15) == 0);
            stall     = ($urandom_range(3) == 0);
            redirect  = ($urandom_range(3) == 0);
            rel       = $urandom_range(1);
            step_half = $urandom_range(1);
            ras_push  = ($urandom_range(2) == 0);
            ras_pop   = ($urandom_range(2) == 0);
            tgt       = ($urandom_range(1) == 1) ? 32'($urandom) : 32'($urandom_range(255));
            trap_vec  = 32'($urandom);
            tick();
            got = {cur0 == m_cur0, cur1 == m_cur1, e0, e1, f0, f1, m0, m1};
            exp = {1'b1, 1'b1, mq0.size() == 0, mq1.size() == 0,
                   mq0.size() == DEPTH, mq1.size() == DEPTH,
                   m_cur0[1] | m_cur0[0], m_cur1[0]};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d: got cur %h/%h flags %b want cur %h/%h flags %b", n, cur0, cur1, got[7:0], m_cur0, m_cur1, exp[7:0]);
            end
        end
        clr();
    endtask

    initial begin
        m_cur0 = RST_VEC;
        m_cur1 = RST_VEC;
        test_reset();
        test_stall_redirect();
        test_call_return();
        test_ras_depth();
        test_trap_reset();
        test_wrap_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
